alu_slice_sequencer: RTL and testbench

//  Drives one 4-bit bitwise logic slice (OR/AND/XOR, same x,y,f interface) across a WIDTH-bit

---
 rtl/alu_slice_sequencer.sv | 95 +++++++++
 tb/tb_alu_slice_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer.sv
// Streams a WIDTH-bit operand pair through a 4-bit logic slice, LSB nibble first, and reassembles the result.
// Optional ALU_SEQ_BACK2BACK_EN: accept new operands in DONE while the result is taken (no IDLE bubble).
module alu_slice_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       slice_x,
  output logic [3:0]       slice_y,
  input  logic [3:0]       slice_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             take_out;
  logic             accept;

  assign res_nxt  = {slice_f, res_sh[WIDTH-1:4]};
  assign take_out = (state == DONE) && out_ready;

`ifdef ALU_SEQ_BACK2BACK_EN
  assign in_ready = !rst && ((state == IDLE) || take_out);
`else
  assign in_ready = !rst && (state == IDLE);
`endif

  assign accept  = in_valid && in_ready;
  assign slice_x = (state == RUN) ? a_sh[3:0] : 4'h0;
  assign slice_y = (state == RUN) ? b_sh[3:0] : 4'h0;
  assign result  = res_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_nxt;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          count  <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            zero      <= (res_nxt == '0);
          end
        end
        DONE: begin
          if (take_out) begin
            out_valid <= 1'b0;
            // In back-to-back mode the accept rides on the same edge as the output handshake.
            if (accept) begin
              a_sh  <= a;
              b_sh  <= b;
              count <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Randomized bench for alu_slice_sequencer; the slice is modelled as bitwise OR and
// expected words come straight from a|b.
module tb_alu_slice_sequencer;
  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 4;
`ifdef ALU_SEQ_BACK2BACK_EN
  localparam int PERIOD = NSLICE + 1;
`else
  localparam int PERIOD = NSLICE + 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       slice_x, slice_y, slice_f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  int checks = 0;
  int errors = 0;

  alu_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .slice_x(slice_x), .slice_y(slice_y), .slice_f(slice_f),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  assign slice_f = slice_x | slice_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation; hold = cycles of out_ready=0 once DONE is reached.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int hold);
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] xs;
    int lat;
    int g;
    exp_r     = av | bv;
    out_ready = (hold == 0);
    g = 0;
    while (!in_ready && g < 50) begin step(); g++; end
    chk("accept_ready", in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0; xs = '0;
    while (!out_valid && lat < 40) begin
      if (lat < NSLICE) xs[lat*4 +: 4] = slice_x;
      step();
      lat++;
    end
    chk("latency", lat, NSLICE);
    chk("slice_x_seq", xs, av);
    chk("result", result, exp_r);
    chk("zero", zero, (exp_r == '0));
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, exp_r);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("pre_release_valid", out_valid, 1);
    chk("pre_release_zero", zero, (exp_r == '0));
    step();
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_result_kept", result, exp_r);
    chk("idle_slice_x", slice_x, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_q[$];
    int acc[$];
    int stale;
    int g;
    logic took;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 0);
    chk("rst_result", result, 0);
    chk("rst_slice_x", slice_x, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    run_op(32'h0000_0009, 32'h0000_0003, 0);
    run_op(32'hF0F0_F0F0, 32'h0F0F_0000, 0);
    run_op(32'h0, 32'h0, 0);
    run_op($urandom, $urandom, 5);

    // Reset in the middle of an operation must leave no out_valid behind.
    a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("after_rst_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) stale++;
      step();
    end
    chk("stale_out_valid", stale, 0);
    run_op(32'h1234_5678, 32'h8000_0001, 0);

    // Random ops, some masked toward zero results.
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) begin ra = '0; rb = '0; end
      else if (i % 3 == 1) begin ra = ra & 32'h0000_00F0; rb = '0; end
      run_op(ra, rb, $urandom_range(0, 3));
    end

    // Streaming: in_valid and out_ready held high, scoreboard on results.
    in_valid = 1'b1; out_ready = 1'b1; a = $urandom; b = $urandom;
    for (int cyc = 0; cyc < 70; cyc++) begin
      took = in_valid && in_ready;
      if (took) begin
        acc.push_back(cyc);
        exp_q.push_back(a | b);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("stream_result", result, exp_q.pop_front());
        else chk("stream_unexpected", 1, 0);
      end
      step();
      if (took) begin a = $urandom; b = $urandom; end
    end
    in_valid = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 40) begin
      if (out_valid) chk("drain_result", result, exp_q.pop_front());
      step();
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("stream_accepts", (acc.size() >= 6), 1);
    for (int i = 1; i < acc.size(); i++)
      chk("issue_period", acc[i] - acc[i-1], PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
